// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: NOP encoding, FSM states, immediate slices, IF/ID bundle.
// Optional squash-on-taken behaviour is enabled by BRANCH_FLUSH_EN.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;

  localparam int PC_MAX_W = 64;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_MAX_W-1:0] pc;
    logic                valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_branch_target.sv
// Branch target adder: pc + (sext(imm26 or imm19) << 2), modulo 2^PC_W.
module branch_target
  import fetch_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [25:0]     i_imm,
  input  logic            i_uncond,
  output logic [PC_W-1:0] o_target
);

  logic [PC_W-1:0] w_off;

  always_comb begin
    if (i_uncond)
      w_off = PC_W'($signed(i_imm[IMM26_MSB:IMM26_LSB]));
    else
      w_off = PC_W'($signed(i_imm[IMM19_MSB:IMM19_LSB]));
  end

  assign o_target = i_pc + (w_off << 2);

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, BOOT/RUN/HOLD control and IF/ID register.
// Define BRANCH_FLUSH_EN to squash the word fetched alongside a taken branch.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            BrTaken,
  input  logic            UncondBr,
  output logic [PC_W-1:0] instr_addr,
  input  logic [31:0]     instr_rdata,
  output logic [31:0]     instructionID,
  output logic [PC_W-1:0] pcID,
  output logic            validID,
  output logic [PC_W-1:0] pc_plus4
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  if_id_t          r_ifid;

  logic [PC_W-1:0] w_pc4;
  logic [PC_W-1:0] w_target;
  logic            w_take;
  if_id_t          w_fetch;

  assign w_pc4  = r_pc + PC_W'(4);
  assign w_take = BrTaken && r_ifid.valid;

  branch_target #(.PC_W(PC_W)) u_bt (
    .i_pc     (pcID),
    .i_imm    (r_ifid.instr[25:0]),
    .i_uncond (UncondBr),
    .o_target (w_target)
  );

  always_comb begin
    w_fetch = '{instr: instr_rdata, pc: PC_MAX_W'(r_pc), valid: 1'b1};
`ifdef BRANCH_FLUSH_EN
    if (w_take) begin
      w_fetch.instr = NOP_INSTR;
      w_fetch.valid = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_ifid  <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else begin
      unique case (r_state)
        BOOT: begin
          r_pc    <= w_pc4;
          r_ifid  <= '{instr: instr_rdata, pc: PC_MAX_W'(r_pc), valid: 1'b1};
          r_state <= RUN;
        end
        RUN, HOLD: begin
          // A stalled branch stays in ID and re-asserts after the stall.
          if (stall) begin
            r_state <= HOLD;
          end else begin
            r_pc    <= w_take ? w_target : w_pc4;
            r_ifid  <= w_fetch;
            r_state <= RUN;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign instr_addr    = r_pc;
  assign instructionID = r_ifid.instr;
  assign pcID          = r_ifid.pc[PC_W-1:0];
  assign validID       = r_ifid.valid;
  assign pc_plus4      = w_pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (reset PC 0 and near-wrap) against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP     = 32'hD503201F;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] W_A     = 32'h17FFFFFF;
  localparam logic [31:0] W_B     = 32'h8B020020;
  localparam logic [31:0] W_B3    = 32'h14000003;
  localparam logic [31:0] W_CBZ   = 32'hB4FFFFC0;
  localparam logic [31:0] W_B4    = 32'h14000004;

  logic clk = 1'b0;
  logic reset, stall, BrTaken, UncondBr;
  logic [31:0] rd0, rd1, id0, id1;
  logic [63:0] a0, a1, p0, p1, pp0, pp1;
  logic v0, v1;

  always #5 clk = ~clk;

  fetch_stage u0 (
    .clk(clk), .reset(reset), .stall(stall), .BrTaken(BrTaken),
    .UncondBr(UncondBr), .instr_addr(a0), .instr_rdata(rd0),
    .instructionID(id0), .pcID(p0), .validID(v0), .pc_plus4(pp0)
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) u1 (
    .clk(clk), .reset(reset), .stall(stall), .BrTaken(BrTaken),
    .UncondBr(UncondBr), .instr_addr(a1), .instr_rdata(rd1),
    .instructionID(id1), .pcID(p1), .validID(v1), .pc_plus4(pp1)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] ipc;
    logic        vld;
    bit          boot;
  } mdl_t;

  mdl_t m [2];
  logic [63:0] ovr_a [$];
  logic [31:0] ovr_d [$];
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] mem(input logic [63:0] a);
    for (int i = ovr_a.size() - 1; i >= 0; i--)
      if (ovr_a[i] == a) return ovr_d[i];
    return 32'h1234_5678 ^ (a[31:0] * 32'h9E37_79B1);
  endfunction

  // One clock of the architectural rules, computed from scratch.
  function automatic mdl_t step(input mdl_t s, input logic [63:0] rpc,
                                input logic rst, input logic stl,
                                input logic br, input logic unc);
    mdl_t n;
    longint off;
    n = s;
    if (rst) begin
      n.pc = rpc; n.ins = NOP; n.ipc = 64'd0; n.vld = 1'b0; n.boot = 1'b1;
      return n;
    end
    if (s.boot) begin
      n.boot = 1'b0; n.pc = s.pc + 64'd4;
      n.ins = mem(s.pc); n.ipc = s.pc; n.vld = 1'b1;
      return n;
    end
    if (stl) return n;
    n.ins = mem(s.pc); n.ipc = s.pc; n.vld = 1'b1;
    if (br && s.vld) begin
      if (unc) off = longint'($signed(s.ins[25:0]));
      else     off = longint'($signed(s.ins[23:5]));
      n.pc = s.ipc + 64'(off * 4);
`ifdef BRANCH_FLUSH_EN
      n.ins = NOP; n.vld = 1'b0;
`endif
    end else begin
      n.pc = s.pc + 64'd4;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    rd0 = mem(a0);
    rd1 = mem(a1);
    m[0] = step(m[0], 64'd0, reset, stall, BrTaken, UncondBr);
    m[1] = step(m[1], WRAP_PC, reset, stall, BrTaken, UncondBr);
    @(posedge clk);
    #1;
    chk("u0.addr",  a0,       m[0].pc);
    chk("u0.instr", 64'(id0), 64'(m[0].ins));
    chk("u0.pcID",  p0,       m[0].ipc);
    chk("u0.valid", 64'(v0),  64'(m[0].vld));
    chk("u0.pc4",   pp0,      m[0].pc + 64'd4);
    chk("u1.addr",  a1,       m[1].pc);
    chk("u1.instr", 64'(id1), 64'(m[1].ins));
    chk("u1.pcID",  p1,       m[1].ipc);
    chk("u1.valid", 64'(v1),  64'(m[1].vld));
    chk("u1.pc4",   pp1,      m[1].pc + 64'd4);
  endtask

  task automatic walk_to(input logic [63:0] target_ipc);
    for (int n = 0; n < 40 && m[0].ipc != target_ipc; n++) tick();
    chk("walk.pcID", p0, target_ipc);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      m[k] = '{pc: 64'd0, ins: NOP, ipc: 64'd0, vld: 1'b0, boot: 1'b1};
    ovr_a.push_back(64'h00); ovr_d.push_back(W_A);
    ovr_a.push_back(64'h04); ovr_d.push_back(W_B);
    ovr_a.push_back(64'h10); ovr_d.push_back(W_B3);
    ovr_a.push_back(64'h40); ovr_d.push_back(W_CBZ);
    ovr_a.push_back(64'h50); ovr_d.push_back(W_B4);
    reset = 1'b1; stall = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;
    rd0 = 32'd0; rd1 = 32'd0;

    // reset then run
    tick(); tick();
    chk("rst.addr",  a0, 64'd0);
    chk("rst.instr", 64'(id0), 64'(NOP));
    chk("rst.valid", 64'(v0), 64'd0);
    chk("rst.wrap",  a1, WRAP_PC);
    reset = 1'b0;
    tick();
    chk("boot.instr", 64'(id0), 64'(W_A));
    chk("boot.pcID",  p0, 64'd0);
    chk("wrap.boot",  a1, 64'd0);
    tick();
    chk("run.addr",  a0, 64'd8);
    chk("run.instr", 64'(id0), 64'(W_B));
    chk("run.pcID",  p0, 64'd4);

    // unconditional branch with delay slot
    walk_to(64'h10);
    BrTaken = 1'b1; UncondBr = 1'b1;
    tick();
    chk("b.addr", a0, 64'h1C);
    chk("b.pcID", p0, 64'h14);
`ifdef BRANCH_FLUSH_EN
    chk("b.slot",  64'(id0), 64'(NOP));
    chk("b.valid", 64'(v0), 64'd0);
`else
    chk("b.slot",  64'(id0), 64'(mem(64'h14)));
    chk("b.valid", 64'(v0), 64'd1);
`endif
    BrTaken = 1'b0;

    // negative CB offset
    walk_to(64'h40);
    BrTaken = 1'b1; UncondBr = 1'b0;
    tick();
    chk("cbz.addr", a0, 64'h38);
    BrTaken = 1'b0;

    // stall with branch pending
    walk_to(64'h50);
    stall = 1'b1; BrTaken = 1'b1; UncondBr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.addr",  a0, 64'h54);
      chk("stall.pcID",  p0, 64'h50);
      chk("stall.instr", 64'(id0), 64'(W_B4));
    end
    stall = 1'b0;
    tick();
    chk("unstall.addr", a0, 64'h60);

    // reset during HOLD with a taken branch
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("mid.addr",  a0, 64'd0);
    chk("mid.instr", 64'(id0), 64'(NOP));
    chk("mid.valid", 64'(v0), 64'd0);
    chk("mid.pcID",  p0, 64'd0);
    reset = 1'b0;
    tick();
    chk("mid.boot.addr",  a0, 64'd4);
    chk("mid.boot.valid", 64'(v0), 64'd1);
    stall = 1'b0; BrTaken = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      BrTaken  = ($urandom_range(0, 9) < 3);
      UncondBr = $urandom_range(0, 1) == 1;
      tick();
    end

    // wrap-around on the near-wrap instance
    reset = 1'b1; stall = 1'b0; BrTaken = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("wrap.pc0",  a1, 64'd0);
    chk("wrap.ipc",  p1, WRAP_PC);
    tick();
    chk("wrap.id0",  p1, 64'd0);
    chk("wrap.ins0", 64'(id1), 64'(W_A));
    BrTaken = 1'b1; UncondBr = 1'b1;
    tick();
    chk("wrap.back", a1, WRAP_PC);
    BrTaken = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the pipelined ARM core.
- Holds the program counter and drives the instruction-memory address.
- Latches the fetched word into the IF/ID register.
- Redirects the PC on branches decided in ID, using BrTaken/UncondBr from the decode control. Branch target is computed here from the IF/ID copy of the instruction and its PC.

Parameters:
- PC_W, 64, program counter / address width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit hold; freezes PC and IF/ID.
- BrTaken  input  1  from decode control; branch in ID is taken this cycle.
- UncondBr  input  1  from decode control; 1 selects imm26 (B), 0 selects imm19 (CB-type).
- instr_addr  output  PC_W  instruction-memory address (= PC).
- instr_rdata  input  32  instruction word; combinational read of instr_addr, same cycle.
- instructionID  output  32  IF/ID instruction; feeds decode control.
- pcID  output  PC_W  PC of instructionID.
- validID  output  1  1 = instructionID is a real fetched instruction, 0 = injected NOP.
- pc_plus4  output  PC_W  PC+4, for debug/trace.

Behaviour:
- Reset (clk edge with reset=1):
  - PC <= RESET_PC.
  - instructionID <= NOP (32'hD503201F; decodes to no writes, no branch).
  - pcID <= 0, validID <= 0, state <= BOOT.
  - Reset dominates all inputs, including mid-stall and mid-branch.
- FSM states:
  - BOOT: one cycle. PC <= PC+4, IF/ID <= {instr_rdata, PC, valid=1}. Goes to RUN. stall and BrTaken are ignored, since ID holds a NOP.
  - RUN: if stall=1, go to HOLD with no state update. Otherwise:
    - next PC = BrTaken ? target : PC+4.
    - IF/ID <= {instr_rdata, PC, 1}.
  - HOLD: PC and IF/ID are unchanged while stall=1. When stall=0, take the RUN update in that same cycle and go to RUN.
- Branch target:
  - target = pcID + (sext(off) << 2), computed at PC_W bits.
  - off = instructionID[25:0] when UncondBr=1, else instructionID[23:5].
  - Sign-extend from bit 25 or bit 18 respectively.
  - Arithmetic is modulo 2^PC_W; wrap-around is not flagged.
- Branch delay: one architectural delay slot. The instruction fetched in the cycle BrTaken=1 enters ID normally. The target is fetched in the next cycle. Redirect latency is 1 cycle.
- Simultaneous stall and BrTaken: stall wins and no redirect happens. The branch stays in ID and re-asserts BrTaken after the stall.
- PC+4 wraps modulo 2^PC_W.
- instr_addr is the registered PC, so there is no combinational path from BrTaken to instr_addr.
- BrTaken/UncondBr with validID=0 are ignored; the FSM gates them.

Optional Feature:
- Macro BRANCH_FLUSH_EN.
- Defined:
  - No delay slot. On a RUN cycle with BrTaken=1 and stall=0, IF/ID <= {NOP, PC, valid=0}; the fetched word is squashed.
  - Taken-branch penalty is 1 bubble.
- Undefined: delay-slot behaviour as above; the fetched word is always kept.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR constant.
  - fetch_state_t enum {BOOT, RUN, HOLD}.
  - Field slice constants IMM26_MSB/LSB and IMM19_MSB/LSB.
  - if_id_t struct {instr, pc, valid}.
- Sub-module branch_target: combinational sign-extend, shift, and add (pcID, instructionID, UncondBr -> target).
- PC register, FSM and IF/ID register stay in fetch_stage.

Test Plan:
- Reset then run: reset for 2 cycles, then release with mem[0]=A, mem[4]=B.
  - BOOT cycle: instr_addr=0, validID=0.
  - Next edge: instructionID=A, pcID=0.
  - Then instr_addr=8, instructionID=B, pcID=4.
- Unconditional branch: B with imm26=3 in ID at pcID=0x10, BrTaken=1, UncondBr=1.
  - Next edge: PC=0x1C.
  - Delay-slot word from 0x14 enters ID with validID=1.
  - With BRANCH_FLUSH_EN it becomes NOP with validID=0.
- Negative CB offset: CBZ with imm19=19'h7FFFE (-2) at pcID=0x40, BrTaken=1, UncondBr=0 -> next PC=0x38.
- Stall with branch: stall=1 for 3 cycles while BrTaken=1.
  - PC, instructionID and pcID are frozen, with no redirect.
  - On the cycle stall=0, redirect occurs at that edge.
- Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC.
  - After BOOT, PC=0.
  - A backward branch at pcID=0 with offset -1 gives target 64'hFFFF_FFFF_FFFF_FFFC.
- Reset mid-operation: assert reset during HOLD with BrTaken=1.
  - Next edge: PC=RESET_PC, instructionID=NOP, validID=0, state=BOOT.
